// File: rtl/ift_mmio_responder.sv
// Taint-tracking MMIO responder: scratch, cycle counter, exit and sticky taint-status registers
// in a 32-byte window. Optional watchdog exit guarded by IFT_MMIO_WATCHDOG_EN.
module ift_mmio_responder #(
    parameter int unsigned              AddrWidth = 32,
    parameter int unsigned              DataWidth = 64,
    parameter logic [AddrWidth-1:0]     BaseAddr  = 32'h1000_0000
`ifdef IFT_MMIO_WATCHDOG_EN
    ,
    parameter logic [31:0]              WatchdogCycles = 32'd1_000_000
`endif
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    input  logic                 req_i_t0,
    input  logic                 we_i,
    input  logic                 we_i_t0,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [AddrWidth-1:0] addr_i_t0,
    input  logic [7:0]           be_i,
    input  logic [7:0]           be_i_t0,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [DataWidth-1:0] wdata_i_t0,
    output logic                 gnt_o,
    output logic                 rvalid_o,
    output logic [DataWidth-1:0] rdata_o,
    output logic [DataWidth-1:0] rdata_o_t0,
    output logic                 done_o,
    output logic [31:0]          exit_code_o,
    output logic [2:0]           taint_status_o
);
    logic                 hit, acc, wr, taint_off;
    logic [1:0]           off;
    logic [DataWidth-1:0] rd, rd_t0;
    logic                 sw_exit, wd_fire;
    logic [2:0]           st_set, st_clr;
    logic                 unused_addr;

    logic                 rvalid_q, done_q;
    logic [DataWidth-1:0] rdata_q, rdata_t0_q, scratch_q, scratch_t0_q, cycle_q;
    logic [DataWidth-1:0] scratch_d, scratch_t0_d;
    logic [31:0]          exit_code_q, exit_t0_q;
    logic [2:0]           status_q;

    assign unused_addr = ^addr_i[2:0];
    assign hit       = (addr_i[AddrWidth-1:5] == BaseAddr[AddrWidth-1:5]);
    assign gnt_o     = req_i & hit;
    assign acc       = gnt_o;
    assign wr        = acc & we_i;
    assign off       = addr_i[4:3];
    assign taint_off = |addr_i_t0[4:3];

    always_comb begin
        rd    = '0;
        rd_t0 = '0;
        case (off)
            2'd0: begin rd = scratch_q; rd_t0 = scratch_t0_q; end
            2'd1: rd = cycle_q;
            2'd2: begin rd = {31'b0, done_q, exit_code_q}; rd_t0 = {32'b0, exit_t0_q}; end
            default: rd = {61'b0, status_q};
        endcase
        // A tainted register select or request may have read any register
        if (taint_off || req_i_t0) rd_t0 = '1;
    end

    always_comb begin
        scratch_d    = scratch_q;
        scratch_t0_d = scratch_t0_q;
        for (int b = 0; b < 8; b++) begin
            if (wr && off == 2'd0 && be_i[b]) begin
                scratch_d[b*8 +: 8]    = wdata_i[b*8 +: 8];
                scratch_t0_d[b*8 +: 8] = taint_off ? 8'hFF :
                    (wdata_i_t0[b*8 +: 8] | {8{be_i_t0[b]}} | {8{we_i_t0}});
            end
        end
    end

    assign sw_exit = wr && off == 2'd2 && be_i[0] && !done_q;
`ifdef IFT_MMIO_WATCHDOG_EN
    assign wd_fire = !done_q && (cycle_q == {32'b0, WatchdogCycles});
`else
    assign wd_fire = 1'b0;
`endif

    assign st_set = {acc & (req_i_t0 | we_i_t0), acc & (|addr_i_t0), wr & (|wdata_i_t0)};
    assign st_clr = (wr && off == 2'd3 && be_i[0]) ? wdata_i[2:0] : 3'b0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            rdata_t0_q   <= '0;
            scratch_q    <= '0;
            scratch_t0_q <= '0;
            cycle_q      <= '0;
            done_q       <= 1'b0;
            exit_code_q  <= '0;
            exit_t0_q    <= '0;
            status_q     <= '0;
        end else begin
            rvalid_q     <= acc;
            rdata_q      <= (acc && !we_i) ? rd : '0;
            rdata_t0_q   <= (acc && !we_i) ? rd_t0 : '0;
            scratch_q    <= scratch_d;
            scratch_t0_q <= scratch_t0_d;
            cycle_q      <= cycle_q + 1'b1;
            status_q     <= (status_q & ~st_clr) | st_set;
            // Software exit takes priority over the watchdog
            if (sw_exit) begin
                done_q      <= 1'b1;
                exit_code_q <= wdata_i[31:0];
                exit_t0_q   <= wdata_i_t0[31:0];
            end else if (wd_fire) begin
                done_q      <= 1'b1;
                exit_code_q <= 32'hDEAD_0001;
                exit_t0_q   <= '0;
            end
        end
    end

    assign rvalid_o       = rvalid_q;
    assign rdata_o        = rdata_q;
    assign rdata_o_t0     = rdata_t0_q;
    assign done_o         = done_q;
    assign exit_code_o    = exit_code_q;
    assign taint_status_o = status_q;
endmodule

// File: tb/tb_ift_mmio_responder.sv
// Directed bench for ift_mmio_responder: register map, taint propagation, decode miss, reset, exit.
module tb_ift_mmio_responder;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 0, req_i_t0 = 0, we_i = 0, we_i_t0 = 0;
    logic [31:0] addr_i = 0, addr_i_t0 = 0;
    logic [7:0]  be_i = 0, be_i_t0 = 0;
    logic [63:0] wdata_i = 0, wdata_i_t0 = 0;
    logic        gnt_o, rvalid_o, done_o;
    logic [63:0] rdata_o, rdata_o_t0;
    logic [31:0] exit_code_o;
    logic [2:0]  taint_status_o;
    int          total = 0, bad = 0;

    always #5 clk_i = ~clk_i;

`ifdef IFT_MMIO_WATCHDOG_EN
    ift_mmio_responder #(.WatchdogCycles(32'd100)) dut (
`else
    ift_mmio_responder dut (
`endif
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_i(req_i), .req_i_t0(req_i_t0), .we_i(we_i), .we_i_t0(we_i_t0),
        .addr_i(addr_i), .addr_i_t0(addr_i_t0), .be_i(be_i), .be_i_t0(be_i_t0),
        .wdata_i(wdata_i), .wdata_i_t0(wdata_i_t0),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .rdata_o_t0(rdata_o_t0),
        .done_o(done_o), .exit_code_o(exit_code_o), .taint_status_o(taint_status_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    // Called #1 after a posedge; returns #1 after the accepting edge (response cycle).
    task automatic go(input logic we, input logic [7:0] off, input logic [7:0] be, input logic [63:0] wd);
        req_i = 1; we_i = we; addr_i = BASE + {24'b0, off}; be_i = be; wdata_i = wd;
        #1 chk("gnt", {63'b0, gnt_o}, 64'd1);
        @(posedge clk_i); #1;
        req_i = 0; we_i = 0; addr_i = 0; be_i = 0; wdata_i = 0;
        req_i_t0 = 0; we_i_t0 = 0; addr_i_t0 = 0; be_i_t0 = 0; wdata_i_t0 = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_rvalid", {63'b0, rvalid_o}, 64'd0);
        chk("rst_rdata", rdata_o, 64'd0);
        chk("rst_done", {63'b0, done_o}, 64'd0);
        chk("rst_exit", {32'b0, exit_code_o}, 64'd0);
        chk("rst_status", {61'b0, taint_status_o}, 64'd0);
        rst_ni = 1;

        // CYCLE read accepted at the 11th edge after release samples 10
        repeat (10) @(posedge clk_i);
        #1;
        go(0, 8'h08, 8'hFF, 0);
        chk("cyc_rvalid", {63'b0, rvalid_o}, 64'd1);
        chk("cyc_rdata", rdata_o, 64'd10);
        chk("cyc_t0", rdata_o_t0, 64'd0);
        @(posedge clk_i); #1;
        chk("rvalid_one_cycle", {63'b0, rvalid_o}, 64'd0);
        chk("rdata_idle", rdata_o, 64'd0);

        // SCRATCH byte-masked write with data taint
        wdata_i_t0 = 64'h0000_0000_0000_FF00;
        go(1, 8'h00, 8'h0F, 64'h1122_3344_5566_7788);
        chk("wr_rvalid", {63'b0, rvalid_o}, 64'd1);
        go(0, 8'h00, 8'hFF, 0);
        chk("scr_rdata", rdata_o, 64'h0000_0000_5566_7788);
        chk("scr_t0", rdata_o_t0, 64'h0000_0000_0000_FF00);
        chk("scr_status", {61'b0, taint_status_o}, 64'd1);

        // byte-enable taint only marks written bytes whose enable is tainted
        be_i_t0 = 8'h10;
        go(1, 8'h00, 8'h30, 64'hAAAA_BBBB_CCCC_DDDD);
        go(0, 8'h00, 8'hFF, 0);
        chk("scr2_rdata", rdata_o, 64'h0000_BBBB_5566_7788);
        chk("scr2_t0", rdata_o_t0, 64'h0000_00FF_0000_FF00);

        // EXIT: first write latches, second is ignored
        wdata_i_t0 = 64'h0000_0000_0000_00F0;
        go(1, 8'h10, 8'h01, 64'h1);
        chk("exit_done", {63'b0, done_o}, 64'd1);
        chk("exit_code", {32'b0, exit_code_o}, 64'd1);
        go(1, 8'h10, 8'h01, 64'h5);
        chk("exit_hold", {32'b0, exit_code_o}, 64'd1);
        go(0, 8'h10, 8'hFF, 0);
        chk("exit_rdata", rdata_o, 64'h0000_0001_0000_0001);
        chk("exit_t0", rdata_o_t0, 64'h0000_0000_0000_00F0);

        // conservative read taint from address select and from request taint
        addr_i_t0 = 32'h8;
        go(0, 8'h00, 8'hFF, 0);
        chk("addrt_t0", rdata_o_t0, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addrt_status", {61'b0, taint_status_o}, 64'd3);
        req_i_t0 = 1;
        go(0, 8'h08, 8'hFF, 0);
        chk("reqt_t0", rdata_o_t0, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("reqt_status", {61'b0, taint_status_o}, 64'd7);

        // TAINT_STATUS read and write-1-to-clear
        go(0, 8'h18, 8'hFF, 0);
        chk("ts_rdata", rdata_o, 64'd7);
        chk("ts_t0", rdata_o_t0, 64'd0);
        go(1, 8'h18, 8'h01, 64'h7);
        chk("ts_clr", {61'b0, taint_status_o}, 64'd0);
        go(0, 8'h18, 8'hFF, 0);
        chk("ts_rd0", rdata_o, 64'd0);

        // set beats clear in the same cycle
        addr_i_t0 = 32'h1;
        go(1, 8'h18, 8'h01, 64'h7);
        chk("ts_setwins", {61'b0, taint_status_o}, 64'd2);

        // out-of-window request
        req_i = 1; addr_i = BASE + 32'h40;
        #1 chk("miss_gnt", {63'b0, gnt_o}, 64'd0);
        @(posedge clk_i); #1;
        req_i = 0; addr_i = 0;
        chk("miss_rvalid", {63'b0, rvalid_o}, 64'd0);

        // reset while a read response is pending
        req_i = 1; addr_i = BASE;
        @(posedge clk_i); #1;
        req_i = 0; addr_i = 0;
        chk("pend_rvalid", {63'b0, rvalid_o}, 64'd1);
        rst_ni = 0;
        #1 chk("rstmid_rvalid", {63'b0, rvalid_o}, 64'd0);
        chk("rstmid_done", {63'b0, done_o}, 64'd0);
        @(posedge clk_i); #1;
        rst_ni = 1;
        repeat (2) begin
            @(posedge clk_i); #1;
            chk("post_rst_rvalid", {63'b0, rvalid_o}, 64'd0);
        end

        // no EXIT write: watchdog fires when CYCLE reaches 100, else done stays low
        rst_ni = 0;
        @(posedge clk_i); #1;
        rst_ni = 1;
        repeat (100) @(posedge clk_i);
        #1 chk("wd_before", {63'b0, done_o}, 64'd0);
        @(posedge clk_i); #1;
`ifdef IFT_MMIO_WATCHDOG_EN
        chk("wd_done", {63'b0, done_o}, 64'd1);
        chk("wd_code", {32'b0, exit_code_o}, 64'hDEAD_0001);
`else
        chk("nowd_done", {63'b0, done_o}, 64'd0);
        chk("nowd_code", {32'b0, exit_code_o}, 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ift_mmio_responder.md
Name: ift_mmio_responder

Overview:
- Taint-tracking MMIO responder on the core's req/we/addr/be/data memory port, with a `_t0` shadow on every signal.
- Sits beside the SRAM responder in the tiny SoC and answers only requests that decode into its 32-byte window.
- Holds a scratch register, a free-running cycle counter, the end-of-benchmark exit register and a sticky taint-observation register.
- Reports benchmark completion and the exit code to the testbench.

Parameters:
- AddrWidth, 32, request address width.
- DataWidth, 64, data width; fixed at 64 (8 byte enables).
- BaseAddr, 32'h1000_0000, window base; must be 32-byte aligned; window is BaseAddr..BaseAddr+0x1F.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i / req_i_t0  in  1 / 1  request and its taint.
- we_i / we_i_t0  in  1 / 1  write enable and its taint.
- addr_i / addr_i_t0  in  AddrWidth / AddrWidth  byte address and its taint.
- be_i / be_i_t0  in  8 / 8  byte enables and their taint.
- wdata_i / wdata_i_t0  in  64 / 64  write data and its taint.
- gnt_o  out  1  grant; combinational.
- rvalid_o  out  1  response valid.
- rdata_o / rdata_o_t0  out  64 / 64  read data and its taint.
- done_o  out  1  end-of-benchmark flag.
- exit_code_o  out  32  exit code.
- taint_status_o  out  3  sticky taint flags.

Behaviour:
- Reset: every register and output is 0.
- Decode:
  - hit = (addr_i[AddrWidth-1:5] == BaseAddr[AddrWidth-1:5]).
  - gnt_o = req_i & hit.
  - Non-hit requests are ignored entirely: no grant, no rvalid_o.
- Latency:
  - An accepted request (req_i & gnt_o) produces rvalid_o = 1 for exactly one cycle, in the following cycle.
  - This applies to reads and writes alike.
  - rdata_o / rdata_o_t0 are valid only while rvalid_o = 1 and are 0 otherwise.
  - Back-to-back requests are accepted every cycle.
- Register map (offset = addr_i[4:3]):
  - 0x00 SCRATCH, RW:
    - Byte-masked write of wdata_i.
    - Each written byte's taint = wdata_i_t0 byte | {8{be_i_t0[b]}} | {8{we_i_t0}}.
  - 0x08 CYCLE, RO:
    - 64-bit counter, +1 every cycle after reset; wraps from all-ones to 0.
    - Reads return the value sampled in the accept cycle, with taint 0.
    - Writes are ignored.
  - 0x10 EXIT:
    - A write with be_i[0] = 1 while done_o = 0 sets done_o = 1 and exit_code_o = wdata_i[31:0] from the next cycle.
    - The taint of wdata_i[31:0] is stored alongside.
    - Later writes are ignored; done_o holds until reset.
    - Read returns {31'b0, done_o, exit_code_o} with taint {32'b0, stored exit taint}.
  - 0x18 TAINT_STATUS:
    - Sticky flags: bit0 = |wdata_i_t0 on an accepted write; bit1 = |addr_i_t0 on an accepted request; bit2 = req_i_t0 | we_i_t0 on an accepted request.
    - Write with be_i[0] = 1 is write-1-to-clear on wdata_i[2:0].
    - If a flag's set condition and its clear fall in the same cycle, set wins.
    - Read returns the flags zero-extended, taint 0.
    - taint_status_o mirrors the flags.
- Conservative taint:
  - If addr_i_t0[4:3] != 0, or req_i_t0 = 1, on an accepted read, rdata_o_t0 is all ones.
  - If addr_i_t0[4:3] != 0 on an accepted write, SCRATCH taint becomes all ones for every byte where be_i = 1.
- Reset mid-transaction: a pending rvalid_o is dropped; no response is issued after reset deasserts.

Optional Feature:
- Macro: IFT_MMIO_WATCHDOG_EN.
- With it defined:
  - Added parameter WatchdogCycles, default 32'd1_000_000.
  - When CYCLE reaches WatchdogCycles while done_o = 0, the block forces done_o = 1 and exit_code_o = 32'hDEAD_0001, with exit taint 0.
  - If a software EXIT write lands in the same cycle, the software write wins.
- Without it: no parameter, no comparator; done_o is set only by software.

Test Plan:
- Reset, then read CYCLE at cycle 10 -> rvalid_o at cycle 11, rdata_o = 10 ± the fixed accept offset, rdata_o_t0 = 0.
- Write SCRATCH = 64'h1122_3344_5566_7788, be = 8'h0F, wdata_i_t0 = 64'h0000_0000_0000_FF00, then read back -> rdata_o = 64'h0000_0000_5566_7788, rdata_o_t0 = 64'h0000_0000_0000_FF00, taint_status_o = 3'b001.
- Write EXIT = 32'h0000_0001, then write EXIT = 32'h5 -> done_o = 1, exit_code_o stays 32'h1.
- Read SCRATCH with addr_i_t0 = 32'h8 -> rdata_o_t0 = all ones, taint_status_o[1] = 1; then write TAINT_STATUS = 3'b111 -> flags read 0.
- Request to BaseAddr + 0x40 -> gnt_o = 0, rvalid_o stays 0; assert rst_ni low during a read accept -> no rvalid_o after release.
- With IFT_MMIO_WATCHDOG_EN and WatchdogCycles = 100, no EXIT write -> done_o = 1 and exit_code_o = 32'hDEAD_0001 at cycle 101.
